// File: rtl/fp32_mul_sched.sv
// fp32_mul_sched: round-robin scheduler sharing one fp32 multiplier among NUM_REQ requesters.
// The product is captured into stage 0 and travels a PIPE_STAGES-deep register pipeline that
// stalls as a whole when the tagged response port is backpressured.
// Optional build macro FP32_MUL_SCHED_STATS_EN adds stat_issued / stat_stalls counters.
module fp32_mul_sched #(
    parameter int unsigned  NUM_REQ     = 4,
    parameter int unsigned  PIPE_STAGES = 2,
    localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 busy
`ifdef FP32_MUL_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stalls
`endif
);

    // Truncating fp32 multiply; exponent field wraps to 8 bits once range checks pass.
    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] ma;
        logic [47:0] mb;
        logic [47:0] prod;
        logic [9:0]  exp_sum;
        logic [22:0] mant;
        logic [31:0] res;
        sign    = a[31] ^ b[31];
        ea      = a[30:23];
        eb      = b[30:23];
        a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
        // Denormal inputs are treated as zero.
        a_zero  = (ea == 8'd0);
        b_zero  = (eb == 8'd0);
        ma      = {24'd0, 1'b1, a[22:0]};
        mb      = {24'd0, 1'b1, b[22:0]};
        prod    = ma * mb;
        exp_sum = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} - 10'd127;
        mant    = prod[47] ? prod[46:24] : prod[45:23];
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            res = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res = 32'h0000_0000;
        end else if (exp_sum[9] || (exp_sum == 10'd0)) begin
            res = 32'h0000_0000;
        end else if (exp_sum >= 10'd255) begin
            res = {sign, 8'hFF, 23'd0};
        end else begin
            res = {sign, exp_sum[7:0], mant};
        end
        return res;
    endfunction

    logic [PIPE_STAGES-1:0] v_q;
    logic [ID_W-1:0]        id_q  [PIPE_STAGES];
    logic [31:0]            res_q [PIPE_STAGES];
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        ptr_d;
    logic [ID_W-1:0]        grant;
    logic                   grant_found;
    logic                   advance;
    logic                   issue;
    logic [31:0]            op_a;
    logic [31:0]            op_b;
    logic [31:0]            product;

    assign advance = !v_q[PIPE_STAGES-1] || rsp_ready;

    // Round-robin scan starting at ptr; first valid requester wins.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            if (!grant_found && req_valid[(int'(ptr_q) + off) % int'(NUM_REQ)]) begin
                grant_found = 1'b1;
                grant       = ID_W'((int'(ptr_q) + off) % int'(NUM_REQ));
            end
        end
    end

    // One-hot ready to the granted requester, only when the pipeline can move.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = advance && grant_found && req_valid[i] && (grant == ID_W'(i));
        end
    end

    assign issue   = |req_ready;
    assign op_a    = req_a[32*int'(grant) +: 32];
    assign op_b    = req_b[32*int'(grant) +: 32];
    assign product = fp32_mul(op_a, op_b);

    // Explicit wrap keeps the pointer legal for non-power-of-two NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Pipeline and pointer registers; everything holds while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            ptr_q <= '0;
            for (int k = 0; k < int'(PIPE_STAGES); k++) begin
                id_q[k]  <= '0;
                res_q[k] <= '0;
            end
        end else if (advance) begin
            v_q[0]   <= issue;
            id_q[0]  <= grant;
            res_q[0] <= product;
            for (int k = 1; k < int'(PIPE_STAGES); k++) begin
                v_q[k]   <= v_q[k-1];
                id_q[k]  <= id_q[k-1];
                res_q[k] <= res_q[k-1];
            end
            ptr_q <= ptr_d;
        end
    end

    assign rsp_valid  = v_q[PIPE_STAGES-1];
    assign rsp_id     = id_q[PIPE_STAGES-1];
    assign rsp_result = res_q[PIPE_STAGES-1];
    assign busy       = |v_q;

`ifdef FP32_MUL_SCHED_STATS_EN
    // Free-running issue and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stalls <= '0;
        end else begin
            if (issue) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fp32_mul_sched.sv
// Directed testbench for fp32_mul_sched (NUM_REQ=4 instance plus a NUM_REQ=3 instance).
// Build with FP32_MUL_SCHED_STATS_EN defined to also check the statistics counters.
module tb_fp32_mul_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         busy;

    logic [2:0]   req_valid3;
    logic [2:0]   req_ready3;
    logic [95:0]  req_a3;
    logic [95:0]  req_b3;
    logic         rsp_valid3;
    logic         rsp_ready3;
    logic [1:0]   rsp_id3;
    logic [31:0]  rsp_result3;
    logic         busy3;

`ifdef FP32_MUL_SCHED_STATS_EN
    logic [31:0]  stat_issued;
    logic [31:0]  stat_stalls;
    logic [31:0]  stat_issued3;
    logic [31:0]  stat_stalls3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_mul_sched #(.NUM_REQ(4), .PIPE_STAGES(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef FP32_MUL_SCHED_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stalls(stat_stalls)
`endif
    );

    fp32_mul_sched #(.NUM_REQ(3), .PIPE_STAGES(2)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_a      (req_a3),
        .req_b      (req_b3),
        .rsp_valid  (rsp_valid3),
        .rsp_ready  (rsp_ready3),
        .rsp_id     (rsp_id3),
        .rsp_result (rsp_result3),
        .busy       (busy3)
`ifdef FP32_MUL_SCHED_STATS_EN
        ,
        .stat_issued(stat_issued3),
        .stat_stalls(stat_stalls3)
`endif
    );

    // Requester i carries (i+1).0 * 2.0
    task automatic load_rr_operands();
        logic [31:0] a_val [4];
        a_val = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = a_val[i];
            req_b[32*i +: 32] = 32'h4000_0000;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got v=%b busy=%b want 0 0", rsp_valid3, busy3); end
`ifdef FP32_MUL_SCHED_STATS_EN
        checks++; if (stat_issued !== 32'd0 || stat_stalls !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_issued, stat_stalls); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_p [4];
        exp_p = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};
        load_rr_operands();
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, 4'(1 << (c % 4)));
                end
            end
            if (c >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_result !== exp_p[(c - 2) % 4]) begin
                    errors++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d res=%h want v=1 id=%0d res=%h",
                                       c, rsp_valid, rsp_id, rsp_result, (c - 2) % 4, exp_p[(c - 2) % 4]);
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp_early c=%0d got %b want 0", c, rsp_valid); end
            end
        end
    endtask

    task automatic test_single();
        req_a[64 +: 32] = 32'h4000_0000;
        req_b[64 +: 32] = 32'h4040_0000;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 4'b0100 : 4'b0000;
            #1;
            case (c)
                0: begin
                    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
                end
                1: begin
                    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_inflight got v=%b busy=%b want 0 1", rsp_valid, busy); end
                end
                2: begin
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'h40C0_0000) begin
                        errors++; $display("FAIL single_rsp got v=%b id=%0d res=%h want 1 2 40c00000", rsp_valid, rsp_id, rsp_result);
                    end
                end
                default: begin
                    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got v=%b busy=%b want 0 0", rsp_valid, busy); end
                end
            endcase
        end
    endtask

    // Pointer is 3 here: issues go to requester 3 then 0, then the output stalls.
    task automatic test_backpressure();
        load_rr_operands();
        rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 7) ? 4'hF : 4'h0;
            rsp_ready = (c >= 7);
            #1;
            if (c == 0) begin
                checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_fill0 got %b want 1000", req_ready); end
            end else if (c == 1) begin
                checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_fill1 got rdy=%b v=%b want 0001 0", req_ready, rsp_valid); end
            end else if (c <= 6) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'h4100_0000 || req_ready !== 4'd0 || busy !== 1'b1) begin
                    errors++; $display("FAIL bp_stall c=%0d got v=%b id=%0d res=%h rdy=%b busy=%b want 1 3 41000000 0000 1",
                                       c, rsp_valid, rsp_id, rsp_result, req_ready, busy);
                end
            end else if (c == 7) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'h4100_0000) begin
                    errors++; $display("FAIL bp_drain0 got v=%b id=%0d res=%h want 1 3 41000000", rsp_valid, rsp_id, rsp_result);
                end
`ifdef FP32_MUL_SCHED_STATS_EN
                checks++; if (stat_stalls !== 32'd5) begin errors++; $display("FAIL bp_stat_stalls got %0d want 5", stat_stalls); end
                checks++; if (stat_issued !== 32'd11) begin errors++; $display("FAIL bp_stat_issued got %0d want 11", stat_issued); end
`endif
            end else if (c == 8) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'h4000_0000) begin
                    errors++; $display("FAIL bp_drain1 got v=%b id=%0d res=%h want 1 0 40000000", rsp_valid, rsp_id, rsp_result);
                end
            end else begin
                checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%b busy=%b want 0 0", rsp_valid, busy); end
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] sa [4];
        logic [31:0] sb [4];
        logic [31:0] se [4];
        sa = '{32'h7F80_0000, 32'hC000_0000, 32'h0080_0000, 32'h7F00_0000};
        sb = '{32'h0000_0000, 32'h7F80_0000, 32'h0080_0000, 32'h7F00_0000};
        se = '{32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7F80_0000};
        rsp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 4) begin
                req_a[32*c +: 32] = sa[c];
                req_b[32*c +: 32] = sb[c];
                req_valid = 4'(1 << c);
            end else begin
                req_valid = 4'h0;
            end
            #1;
            if (c < 4) begin
                checks++; if (req_ready !== 4'(1 << c)) begin errors++; $display("FAIL sp_ready c=%0d got %b want %b", c, req_ready, 4'(1 << c)); end
            end
            if (c >= 2 && c < 6) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(c - 2) || rsp_result !== se[c - 2]) begin
                    errors++; $display("FAIL sp_rsp%0d got v=%b id=%0d res=%h want 1 %0d %h",
                                       c - 2, rsp_valid, rsp_id, rsp_result, c - 2, se[c - 2]);
                end
            end
            if (c == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_idle got busy=%b want 0", busy); end
            end
        end
    endtask

    // Issue requesters 1 and 2 (pointer ends at 3), then reset with both in flight.
    task automatic test_reset_mid();
        load_rr_operands();
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_issue1 got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_issue2 got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL rm_inflight got v=%b id=%0d want 1 1", rsp_valid, rsp_id); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== 32'd0) begin
            errors++; $display("FAIL rm_async got v=%b busy=%b res=%h want 0 0 0", rsp_valid, busy, rsp_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_lost c=%0d got v=%b busy=%b want 0 0", c, rsp_valid, busy); end
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_num_req3();
        for (int i = 0; i < 3; i++) begin
            req_a3[32*i +: 32] = 32'h3F80_0000;
            req_b3[32*i +: 32] = 32'h3F80_0000;
        end
        rsp_ready3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid3 = (c < 4) ? 3'b111 : 3'b000;
            #1;
            if (c < 4) begin
                checks++;
                if (req_ready3 !== 3'(1 << (c % 3))) begin
                    errors++; $display("FAIL n3_grant c=%0d got %b want %b", c, req_ready3, 3'(1 << (c % 3)));
                end
            end
            if (c >= 2) begin
                checks++;
                if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'((c - 2) % 3) || rsp_result3 !== 32'h3F80_0000) begin
                    errors++; $display("FAIL n3_rsp c=%0d got v=%b id=%0d res=%h want 1 %0d 3f800000",
                                       c, rsp_valid3, rsp_id3, rsp_result3, (c - 2) % 3);
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        req_valid3 = '0;
        req_a3     = '0;
        req_b3     = '0;
        rsp_ready3 = 1'b1;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_special();
        test_reset_mid();
        test_num_req3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp32_mul_sched.md
# fp32_mul_sched

Round-robin scheduler that shares one fp32 multiplier datapath among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle. The product runs through a `PIPE_STAGES`-deep register pipeline and returns on a single tagged response port with backpressure. It sits between PIM compute lanes and the fp32 multiplier, which is instantiated inside this block.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `PIPE_STAGES`, 2: number of result register stages after the multiplier; must be ≥1.
- `ID_W`, derived localparam `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents an operand pair.
- `req_ready`  out  NUM_REQ  bit i: requester i's pair is accepted this cycle; at most one bit set.
- `req_a`  in  32*NUM_REQ  operand a of requester i, in bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand b of requester i, same packing as `req_a`.
- `rsp_valid`  out  1  a result is presented.
- `rsp_ready`  in  1  the consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that issued the result.
- `rsp_result`  out  32  fp32 product.
- `busy`  out  1  at least one pipeline stage holds a valid operation.

## Operation
- Multiply semantics are fixed and bit-exact to the team fp32 multiplier:
  - Sign is the XOR of the operand signs.
  - Biased exponent sum uses 8-bit wrap; 24×24 mantissa multiply; normalize on bit 47; result is truncated, not rounded.
  - NaN and inf×0 return `0x7FC00000`. Inf returns signed inf. A zero operand returns `0x00000000`.
  - Underflow flushes to 0. Overflow returns signed inf.
- `advance = !v[PIPE_STAGES-1] || rsp_ready`. When `advance` is 0, the whole pipeline holds. Bubbles are not collapsed.
- Arbiter:
  - `ptr` is an ID_W-bit round-robin pointer, reset to 0.
  - The grant goes to the first i with `req_valid[i]`, scanning ptr, ptr+1, … mod NUM_REQ.
- `req_ready[i] = advance && req_valid[i] && (grant == i)`. It is combinational and never asserts without the matching `req_valid`.
- Issue means any `req_ready` bit is high. On issue:
  - Stage 0 captures {valid=1, id=grant, product}.
  - `ptr` becomes (grant+1) mod NUM_REQ. When NUM_REQ is not a power of two, wrap explicitly: NUM_REQ-1 → 0.
- If `advance` is high and no request is valid, stage 0 loads valid=0 and `ptr` is unchanged.
- Stage k (k ≥ 1) loads stage k-1 when `advance` is high.
- Outputs are driven from the last stage: `rsp_valid`, `rsp_id`, `rsp_result`.
- `busy` is the OR of all stage valid bits.
- A requester whose `req_valid` drops before it is granted loses nothing. No state is held for requests that were not granted.

## Timing
- Reset values: all stage valids 0, `ptr` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, `busy` 0. The data registers are reset as well.
- Latency: a pair accepted on edge N gives `rsp_valid` high after edge N+PIPE_STAGES-1. That is PIPE_STAGES cycles of visibility after acceptance, provided there is no stall.
- Throughput is one result per cycle while `rsp_ready` stays high.
- Response stall: while `rsp_valid && !rsp_ready`:
  - `rsp_*` and all stages hold stable.
  - All `req_ready` bits are 0.
- If `rsp_ready` is asserted in the same cycle as a stall, a new issue and the response drain happen together on that edge.
- Reset mid-operation: all in-flight results are discarded with no response, and `ptr` returns to 0 asynchronously.
- Fairness: with all requesters continuously valid and no stalls, each is served exactly once every NUM_REQ issues.

## Configuration
- `FP32_MUL_SCHED_STATS_EN`
  - Defined: adds output ports `stat_issued` [31:0] and `stat_stalls` [31:0], both reset to 0.
    - `stat_issued` increments on every issue.
    - `stat_stalls` increments on every cycle with `rsp_valid && !rsp_ready`.
    - Both are free-running and wrap from 0xFFFFFFFF to 0.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single request, default parameters: req 2 sends a=`0x40000000`, b=`0x40400000` → after 2 cycles, `rsp_valid`=1, `rsp_id`=2, `rsp_result`=`0x40C00000`; `busy` is 0 afterward.
- All four requests held valid for 8 issues with `rsp_ready`=1 → grant order 0,1,2,3,0,1,2,3; one response per cycle with matching ids.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with the pipeline full → `rsp_*` stable, all `req_ready`=0, `stat_stalls`=5; release → results drain in order with none lost.
- Special values:
  - inf×0 → `0x7FC00000`.
  - -2.0 × inf (`0xC0000000` × `0x7F800000`) → `0xFF800000`.
  - `0x00800000` × `0x00800000` → `0x00000000`.
- Assert `rst_n`=0 with 2 results in flight → `rsp_valid`=0 immediately; after release, neither result appears and the next grant starts at requester 0.
- NUM_REQ=3 with all requesters valid → grant order 0,1,2,0, confirming the pointer wraps from 2 to 0.
